// File: rtl/i2c_slv_pkg.sv
// Shared definitions for the I2C slave register block.
// Contents: FSM state enum, ACK/NACK bus levels, bit-counter width and
// the counter values the FSM compares against.
package i2c_slv_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RACK,
      S_WAIT
   } state_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   // Counts 0..8 so the read path can tell "8 bits sent" apart from "none yet".
   localparam int BCW = 4;
   localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(7);
   localparam logic [BCW-1:0] BC_DONE = BCW'(8);

endpackage

// File: rtl/i2c_slv_sync_filter.sv
// Synchronizer and edge detector for one I2C line (used once for SCL and
// once for SDA).
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous reset, active-high (line assumed idle high)
//   pad_i  - raw pad level
//   lvl_o  - synchronized (optionally filtered) level
//   rise_o - one-cycle pulse on a 0->1 change of lvl_o
//   fall_o - one-cycle pulse on a 1->0 change of lvl_o
// Build option: define I2C_SLV_GLITCH_FILTER_EN to insert a 3-sample
// majority filter after the synchronizer, rejecting 1-cycle pulses.
module i2c_slv_sync_filter (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pad_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] sync_q;
   logic       prev_q;
   logic       lvl;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], pad_i};
      end
   end

`ifdef I2C_SLV_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       maj_q;

   // Majority of the current and two previous synchronized samples.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= 2'b11;
         maj_q  <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], sync_q[1]};
         maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) |
                   (hist_q[0] & hist_q[1]);
      end
   end

   assign lvl = maj_q;
`else
   assign lvl = sync_q[1];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= lvl;
      end
   end

   assign lvl_o  = lvl;
   assign rise_o = lvl & ~prev_q;
   assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with a 2**AW byte register file. Write: START, addr+W,
// pointer, data... STOP. Read: START, addr+R (optionally after a pointer
// write and repeated START), bytes served from the pointer, auto-increment.
// Ports:
//   wb_clk_i     - system clock, rising edge
//   arst_i       - asynchronous reset, active-high
//   scl_pad_i    - SCL line level
//   sda_pad_i    - SDA line level
//   sda_pad_o    - SDA output value (always 0, open-drain)
//   sda_padoen_o - SDA output enable, active low (0 pulls the line low)
//   busy_o       - high from address match until STOP / next START
//   wr_stb_o     - one-cycle pulse per register write
//   wr_adr_o     - register address of the strobed write
//   wr_dat_o     - data of the strobed write
// Build option: I2C_SLV_GLITCH_FILTER_EN enables the line majority filters.
module i2c_slave_regs
   import i2c_slv_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h02,
   parameter int         AW         = 4
) (
   input  logic          wb_clk_i,
   input  logic          arst_i,
   input  logic          scl_pad_i,
   input  logic          sda_pad_i,
   output logic          sda_pad_o,
   output logic          sda_padoen_o,
   output logic          busy_o,
   output logic          wr_stb_o,
   output logic [AW-1:0] wr_adr_o,
   output logic [7:0]    wr_dat_o
);

   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_slv_sync_filter u_scl (
      .clk_i  (wb_clk_i),
      .rst_i  (arst_i),
      .pad_i  (scl_pad_i),
      .lvl_o  (scl_lvl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_slv_sync_filter u_sda (
      .clk_i  (wb_clk_i),
      .rst_i  (arst_i),
      .pad_i  (sda_pad_i),
      .lvl_o  (sda_lvl),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   state_e           state_q,  state_d;
   logic [BCW-1:0]   bitcnt_q, bitcnt_d;
   logic [7:0]       shift_q,  shift_d;
   logic             rw_q,     rw_d;
   logic [AW-1:0]    ptr_q,    ptr_d;
   logic             oen_q,    oen_d;
   logic             busy_q,   busy_d;
   logic             stb_q,    stb_d;
   logic [AW-1:0]    wadr_q,   wadr_d;
   logic [7:0]       wdat_q,   wdat_d;
   logic             mem_we;
   logic [7:0]       mem_q [2**AW];
   logic [7:0]       rx_byte;

   // Byte as it will stand once the bit on the current SCL rise is shifted in.
   assign rx_byte = {shift_q[6:0], sda_lvl};

   always_ff @(posedge wb_clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= S_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         rw_q     <= 1'b0;
         ptr_q    <= '0;
         oen_q    <= 1'b1;
         busy_q   <= 1'b0;
         stb_q    <= 1'b0;
         wadr_q   <= '0;
         wdat_q   <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         rw_q     <= rw_d;
         ptr_q    <= ptr_d;
         oen_q    <= oen_d;
         busy_q   <= busy_d;
         stb_q    <= stb_d;
         wadr_q   <= wadr_d;
         wdat_q   <= wdat_d;
      end
   end

   always_ff @(posedge wb_clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[ptr_q] <= rx_byte;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      rw_d     = rw_q;
      ptr_d    = ptr_q;
      oen_d    = oen_q;
      busy_d   = busy_q;
      stb_d    = 1'b0;
      wadr_d   = wadr_q;
      wdat_d   = wdat_q;
      mem_we   = 1'b0;

      if (scl_lvl && sda_fall) begin
         state_d  = S_ADDR;
         bitcnt_d = '0;
         oen_d    = 1'b1;
         busy_d   = 1'b0;
      end else if (scl_lvl && sda_rise) begin
         state_d = S_IDLE;
         oen_d   = 1'b1;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               if (scl_rise) begin
                  shift_d  = rx_byte;
                  bitcnt_d = bitcnt_q + BC_ONE;
                  if (bitcnt_q == BC_LAST) begin
                     if (state_q == S_ADDR) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                           state_d = S_ADDR_ACK;
                           busy_d  = 1'b1;
                           rw_d    = rx_byte[0];
                        end else begin
                           state_d = S_WAIT;
                           oen_d   = 1'b1;
                        end
                     end else if (state_q == S_PTR) begin
                        ptr_d   = rx_byte[AW-1:0];
                        state_d = S_PTR_ACK;
                     end else begin
                        mem_we  = 1'b1;
                        stb_d   = 1'b1;
                        wadr_d  = ptr_q;
                        wdat_d  = rx_byte;
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = S_WDATA_ACK;
                     end
                  end
               end
            end
            // ACK states: first SCL fall starts driving low, the second ends
            // the ACK clock. oen_q tells the two falls apart.
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
               if (scl_fall) begin
                  if (oen_q) begin
                     oen_d = ACK;
                  end else if (state_q == S_ADDR_ACK && rw_q) begin
                     state_d  = S_RDATA;
                     bitcnt_d = '0;
                     shift_d  = mem_q[ptr_q];
                     oen_d    = mem_q[ptr_q][7];
                  end else begin
                     state_d  = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
                     bitcnt_d = '0;
                     oen_d    = 1'b1;
                  end
               end
            end
            S_RDATA: begin
               if (scl_rise) begin
                  bitcnt_d = bitcnt_q + BC_ONE;
               end else if (scl_fall) begin
                  // Count 0 means the byte was loaded on a master ACK and
                  // its MSB is not on the line yet.
                  if (bitcnt_q == '0) begin
                     oen_d = shift_q[7];
                  end else if (bitcnt_q == BC_DONE) begin
                     oen_d   = 1'b1;
                     ptr_d   = ptr_q + PTR_ONE;
                     state_d = S_RACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b1};
                     oen_d   = shift_q[6];
                  end
               end
            end
            S_RACK: begin
               if (scl_rise) begin
                  if (sda_lvl == ACK) begin
                     state_d  = S_RDATA;
                     bitcnt_d = '0;
                     shift_d  = mem_q[ptr_q];
                  end else begin
                     state_d = S_WAIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = oen_q;
   assign busy_o       = busy_q;
   assign wr_stb_o     = stb_q;
   assign wr_adr_o     = wadr_q;
   assign wr_dat_o     = wdat_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed plus randomized bench for i2c_slave_regs. A bit-level I2C
// master drives the bus; a register-file model (array + pointer) predicts
// read data and write strobes.
module tb_i2c_slave_regs;
   import i2c_slv_pkg::*;

   localparam logic [6:0] SA = 7'h02;
   localparam int HP = 10;
   localparam int Q  = 5;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;
   logic       sda_pad_o, sda_padoen_o, busy, wr_stb;
   logic [3:0] wr_adr;
   logic [7:0] wr_dat;

   assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

   i2c_slave_regs #(.SLAVE_ADDR(SA), .AW(4)) dut (
      .wb_clk_i     (clk),
      .arst_i       (arst),
      .scl_pad_i    (scl_m),
      .sda_pad_i    (sda_line),
      .sda_pad_o    (sda_pad_o),
      .sda_padoen_o (sda_padoen_o),
      .busy_o       (busy),
      .wr_stb_o     (wr_stb),
      .wr_adr_o     (wr_adr),
      .wr_dat_o     (wr_dat)
   );

   always #5 clk = ~clk;

   int         n_asrt = 0;
   int         n_fail = 0;
   logic [7:0] ref_mem [16];
   int         ref_ptr = 0;
   logic [7:0] wq [$];

   // Strobe log, written only by this process.
   logic [11:0] stb_log [512];
   int          stb_n = 0;
   int          cnt_addr = 0;

   always @(negedge clk) begin
      if (wr_stb === 1'b1 && stb_n < 512) begin
         stb_log[stb_n] <= {wr_adr, wr_dat};
         stb_n <= stb_n + 1;
      end
      if (dut.state_q == S_ADDR) cnt_addr <= cnt_addr + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(HP);
      sda_m = 1'b0; wait_clk(HP);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(HP);
      sda_m = 1'b1; wait_clk(HP);
   endtask

   task automatic bit_io(input logic b, output logic r);
      sda_m = b;    wait_clk(Q);
      scl_m = 1'b1; wait_clk(HP / 2);
      r = sda_line; wait_clk(HP / 2);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(b[i], r);
      bit_io(1'b1, ack);
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i]);
      bit_io(m_ack, r);
   endtask

   // Pointer write followed by the bytes queued in wq.
   task automatic do_write(input logic [7:0] p);
      logic ack;
      int   base;
      logic [11:0] exp_log [$];
      base = stb_n;
      i2c_start();
      write_byte({SA, 1'b0}, ack);
      chk("wr_addr_ack", ack, ACK);
      chk("wr_busy", busy, 1'b1);
      write_byte(p, ack);
      chk("ptr_ack", ack, ACK);
      ref_ptr = p % 16;
      foreach (wq[k]) begin
         write_byte(wq[k], ack);
         chk("data_ack", ack, ACK);
         ref_mem[ref_ptr] = wq[k];
         exp_log.push_back({4'(ref_ptr), wq[k]});
         ref_ptr = (ref_ptr + 1) % 16;
      end
      i2c_stop();
      chk("wr_busy_after_stop", busy, 1'b0);
      chk("stb_count", stb_n - base, exp_log.size());
      foreach (exp_log[k]) chk("stb_adr_dat", stb_log[base + k], exp_log[k]);
   endtask

   // Optional pointer write + repeated START, then n sequential reads.
   task automatic do_read(input logic setp, input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      i2c_start();
      if (setp) begin
         write_byte({SA, 1'b0}, ack);
         chk("rd_ptr_addr_ack", ack, ACK);
         write_byte(p, ack);
         chk("rd_ptr_ack", ack, ACK);
         ref_ptr = p % 16;
         i2c_start();
      end
      write_byte({SA, 1'b1}, ack);
      chk("rd_addr_ack", ack, ACK);
      chk("rd_busy", busy, 1'b1);
      for (int i = 0; i < n; i++) begin
         read_byte((i == n - 1) ? NACK : ACK, d);
         chk("rd_data", d, ref_mem[ref_ptr]);
         ref_ptr = (ref_ptr + 1) % 16;
      end
      chk("rd_released_after_nack", sda_line, 1'b1);
      i2c_stop();
      chk("rd_busy_after_stop", busy, 1'b0);
   endtask

   initial begin
      logic       ack, r;
      int         base, n;
      logic [7:0] p;

      foreach (ref_mem[k]) ref_mem[k] = 8'h00;

      // Reset state
      wait_clk(3);
      @(negedge clk);
      chk("rst_padoen", sda_padoen_o, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_stb", wr_stb, 1'b0);
      chk("rst_adr", wr_adr, 4'h0);
      chk("rst_dat", wr_dat, 8'h00);
      arst = 1'b0;
      wait_clk(5);

      // Plan 1: pointer 5, two data bytes
      wq = '{8'hA5, 8'h3C};
      do_write(8'h05);

      // Plan 2: read back with ACK then NACK
      do_read(1'b1, 8'h05, 2);

      // Plan 3: wrong address is ignored
      base = stb_n;
      i2c_start();
      write_byte({7'h05, 1'b0}, ack);
      chk("wrong_addr_nack", ack, NACK);
      chk("wrong_addr_busy", busy, 1'b0);
      i2c_stop();
      chk("wrong_addr_no_stb", stb_n - base, 0);

      // Plan 4: pointer wrap, upper pointer bits ignored
      wq = '{8'h11, 8'h22};
      do_write(8'hFF);
      do_read(1'b1, 8'h0F, 2);

      // Randomized writes and reads against the model
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 3);
         wq = {};
         for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
         do_write(8'($urandom_range(0, 255)));
      end
      for (int t = 0; t < 4; t++) begin
         p = 8'($urandom_range(0, 255));
         do_read(1'b1, p, $urandom_range(1, 4));
      end
      // Continue from the retained pointer without a pointer write
      do_read(1'b0, 8'h00, 2);

      // Plan 5: reset while the slave drives a '0' read bit
      wq = '{8'hA5};
      do_write(8'h05);
      i2c_start();
      write_byte({SA, 1'b0}, ack);
      write_byte(8'h05, ack);
      i2c_start();
      write_byte({SA, 1'b1}, ack);
      chk("rst5_addr_ack", ack, ACK);
      bit_io(1'b1, r);
      chk("rst5_msb", r, 1'b1);
      wait_clk(Q);
      chk("rst5_driving_zero", sda_padoen_o, 1'b0);
      @(negedge clk);
      arst = 1'b1;
      #1;
      chk("rst5_padoen_immediate", sda_padoen_o, 1'b1);
      chk("rst5_busy", busy, 1'b0);
      wait_clk(2);
      @(negedge clk);
      arst = 1'b0;
      foreach (ref_mem[k]) ref_mem[k] = 8'h00;
      ref_ptr = 0;
      i2c_stop();
      do_read(1'b0, 8'h00, 1);

      // Plan 6: single-cycle SDA low pulse with SCL high
      wait_clk(HP);
      base = cnt_addr;
      @(posedge clk); #1 sda_m = 1'b0;
      @(posedge clk); #1 sda_m = 1'b1;
      wait_clk(20);
`ifdef I2C_SLV_GLITCH_FILTER_EN
      chk("glitch_start", (cnt_addr != base), 1'b0);
`else
      chk("glitch_start", (cnt_addr != base), 1'b1);
`endif
      chk("glitch_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
